ula_control_unit: RTL and testbench

Multicycle control FSM for the 16-bit datapath built around the ULA (A register, G register, R0..R7, shared bus).
- Latches a 9-bit instruction word, then sequences bus drivers, register enables and ULA OpSelect over 1–3 execute steps.
- Signals completion with a one-cycle Done pulse.
- Sits between the instruction source (DIN/Run) and the datapath register file, muxes and ULA.

---
 rtl/ula_control_unit_pkg.sv | 43 ++++
 rtl/ula_control_unit_if.sv | 29 ++
 rtl/ula_control_unit_dec3to8.sv | 11 +
 rtl/ula_control_unit.sv | 138 +++++++++++++
 tb/tb_ula_control_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ula_control_unit_pkg.sv
// Shared constants for the ULA control unit: opcodes, ULA selects, IR fields, states.
// The TRAP state only exists when CU_ILLEGAL_TRAP_EN is defined.
package cu_pkg;
   localparam int NREGS = 8;
   localparam int IRW   = 9;

   // IR layout, MSB first: opcode | Rx | Ry
   localparam int OP_HI = 8;
   localparam int OP_LO = 6;
   localparam int RX_HI = 5;
   localparam int RX_LO = 3;
   localparam int RY_HI = 2;
   localparam int RY_LO = 0;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_OUT  = 3'b101;

   localparam logic [2:0] ULA_ADD  = 3'b000;
   localparam logic [2:0] ULA_SUB  = 3'b001;
   localparam logic [2:0] ULA_NAND = 3'b010;
   localparam logic [2:0] ULA_OUT  = 3'b100;

`ifdef CU_ILLEGAL_TRAP_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_TRAP = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_T1   = 2'd1,
      S_T2   = 2'd2,
      S_T3   = 2'd3
   } state_t;
`endif
endpackage

// File: rtl/ula_control_unit_if.sv
// Control-unit <-> instruction source / datapath signal bundle.
// master = control unit side, slave = datapath / stimulus side.
interface ula_control_unit_if;
   import cu_pkg::*;

   logic             Run;
   logic [IRW-1:0]   DIN;
   logic             IRin;
   logic [NREGS-1:0] Rin;
   logic [NREGS-1:0] Rout;
   logic             DINout;
   logic             Ain;
   logic             Gin;
   logic             Gout;
   logic             OUTin;
   logic [2:0]       OpSelect;
   logic             Done;
   logic             Illegal;

   modport master (
      input  Run, DIN,
      output IRin, Rin, Rout, DINout, Ain, Gin, Gout, OUTin, OpSelect, Done, Illegal
   );

   modport slave (
      output Run, DIN,
      input  IRin, Rin, Rout, DINout, Ain, Gin, Gout, OUTin, OpSelect, Done, Illegal
   );
endinterface

// File: rtl/ula_control_unit_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8 (
   input  logic       en_i,
   input  logic [2:0] sel_i,
   output logic [7:0] onehot_o
);
   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[sel_i] = 1'b1;
   end
endmodule

// File: rtl/ula_control_unit.sv
// Multicycle control FSM for the ULA datapath: IDLE -> T1 [-> T2 -> T3] -> IDLE, one-cycle Done.
// Optional CU_ILLEGAL_TRAP_EN: opcodes 110/111 lock into TRAP (Illegal=1) until resetn.
module ula_control_unit
   import cu_pkg::*;
(
   input  logic               clock,
   input  logic               resetn,
   ula_control_unit_if.master bus
);
   state_t         state_q, state_d;
   logic [IRW-1:0] ir_q, ir_d;
   logic [2:0]     op, rx, ry, rout_sel;
   logic           rin_en, rout_en;
   logic           dinout, ain, gin, gout, outin, done, illegal;
   logic [2:0]     opsel;

   assign op = ir_q[OP_HI:OP_LO];
   assign rx = ir_q[RX_HI:RX_LO];
   assign ry = ir_q[RY_HI:RY_LO];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      rin_en   = 1'b0;
      rout_en  = 1'b0;
      rout_sel = rx;
      dinout   = 1'b0;
      ain      = 1'b0;
      gin      = 1'b0;
      gout     = 1'b0;
      outin    = 1'b0;
      done     = 1'b0;
      illegal  = 1'b0;
      opsel    = ULA_ADD;
      case (state_q)
         S_IDLE: begin
            if (bus.Run) begin
               ir_d    = bus.DIN;
               state_d = S_T1;
            end
         end
         S_T1: begin
            state_d = S_IDLE;
            case (op)
               OP_MV: begin
                  rout_en  = 1'b1;
                  rout_sel = ry;
                  rin_en   = 1'b1;
                  done     = 1'b1;
               end
               OP_MVI: begin
                  dinout = 1'b1;
                  rin_en = 1'b1;
                  done   = 1'b1;
               end
               OP_ADD, OP_SUB, OP_NAND, OP_OUT: begin
                  rout_en = 1'b1;
                  ain     = 1'b1;
                  state_d = S_T2;
               end
               default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                  state_d = S_TRAP;
`else
                  done = 1'b1;
`endif
               end
            endcase
         end
         S_T2: begin
            gin     = 1'b1;
            state_d = S_T3;
            // out passes A through the ULA, so nothing drives the bus this step
            if (op == OP_OUT) begin
               opsel = ULA_OUT;
            end else begin
               rout_en  = 1'b1;
               rout_sel = ry;
               case (op)
                  OP_SUB:  opsel = ULA_SUB;
                  OP_NAND: opsel = ULA_NAND;
                  default: opsel = ULA_ADD;
               endcase
            end
         end
         S_T3: begin
            gout    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
            if (op == OP_OUT) outin  = 1'b1;
            else              rin_en = 1'b1;
         end
`ifdef CU_ILLEGAL_TRAP_EN
         S_TRAP: begin
            illegal = 1'b1;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   dec3to8 u_rin_dec (
      .en_i     (rin_en),
      .sel_i    (rx),
      .onehot_o (bus.Rin)
   );

   dec3to8 u_rout_dec (
      .en_i     (rout_en),
      .sel_i    (rout_sel),
      .onehot_o (bus.Rout)
   );

   // Gated by resetn so every output reads 0 while reset is held.
   assign bus.IRin     = (state_q == S_IDLE) && bus.Run && resetn;
   assign bus.DINout   = dinout;
   assign bus.Ain      = ain;
   assign bus.Gin      = gin;
   assign bus.Gout     = gout;
   assign bus.OUTin    = outin;
   assign bus.OpSelect = opsel;
   assign bus.Done     = done;
`ifdef CU_ILLEGAL_TRAP_EN
   assign bus.Illegal  = illegal;
`else
   assign bus.Illegal  = 1'b0;
`endif
endmodule

// File: tb/tb_ula_control_unit.sv
// Table-driven, scoreboarded bench for ula_control_unit; Rin/Rout bit i = Ri.
module tb_ula_control_unit;
   typedef struct packed {
      logic       irin;
      logic [7:0] rin;
      logic [7:0] rout;
      logic       dinout;
      logic       ain;
      logic       gin;
      logic       gout;
      logic       outin;
      logic [2:0] op;
      logic       done;
      logic       ill;
   } out_t;

   typedef struct {
      logic [8:0] din;
      int         n;
      out_t       e[4];
      string      name;
   } vec_t;

`ifdef CU_ILLEGAL_TRAP_EN
   localparam int NV = 6;
`else
   localparam int NV = 8;
`endif

   logic clock = 1'b0;
   logic resetn = 1'b0;
   ula_control_unit_if bus ();

   ula_control_unit dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int   n_pass = 0;
   int   n_total = 0;
   out_t sb[$];
   vec_t vt[NV];
   out_t Z, ISS;

   function automatic out_t mk(input logic irin, input int rin, input int rout, input logic dinout,
                               input logic ain, input logic gin, input logic gout, input logic outin,
                               input logic [2:0] op, input logic done, input logic ill = 1'b0);
      out_t o;
      o = '0;
      o.irin = irin;
      if (rin >= 0) o.rin[rin[2:0]] = 1'b1;
      if (rout >= 0) o.rout[rout[2:0]] = 1'b1;
      o.dinout = dinout;
      o.ain = ain;
      o.gin = gin;
      o.gout = gout;
      o.outin = outin;
      o.op = op;
      o.done = done;
      o.ill = ill;
      return o;
   endfunction

   function automatic out_t sample();
      return {bus.IRin, bus.Rin, bus.Rout, bus.DINout, bus.Ain, bus.Gin, bus.Gout,
              bus.OUTin, bus.OpSelect, bus.Done, bus.Illegal};
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cycle(input logic run, input logic [8:0] din, input string name);
      out_t exp;
      @(negedge clock);
      bus.Run = run;
      bus.DIN = din;
      #1;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL %s: scoreboard empty, got %h expected an entry", name, sample());
      end else begin
         exp = sb.pop_front();
         check(name, sample(), exp);
      end
   endtask

   task automatic reset_pulse(input string name);
      out_t exp;
      @(negedge clock);
      bus.Run = 1'b0;
      resetn = 1'b0;
      #1;
      sb.push_back(Z);
      exp = sb.pop_front();
      check(name, sample(), exp);
      @(negedge clock);
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      Z   = '0;
      ISS = mk(1, -1, -1, 0, 0, 0, 0, 0, 3'b000, 0);

      vt[0].din = 9'b001_010_000; vt[0].n = 1; vt[0].name = "mvi R2";
      vt[0].e[0] = ISS; vt[0].e[1] = mk(0, 2, -1, 1, 0, 0, 0, 0, 3'b000, 1); vt[0].e[2] = Z; vt[0].e[3] = Z;
      vt[1].din = 9'b000_100_110; vt[1].n = 1; vt[1].name = "mv R4,R6";
      vt[1].e[0] = ISS; vt[1].e[1] = mk(0, 4, 6, 0, 0, 0, 0, 0, 3'b000, 1); vt[1].e[2] = Z; vt[1].e[3] = Z;
      vt[2].din = 9'b010_001_011; vt[2].n = 3; vt[2].name = "add R1,R3";
      vt[2].e[0] = ISS;
      vt[2].e[1] = mk(0, -1, 1, 0, 1, 0, 0, 0, 3'b000, 0);
      vt[2].e[2] = mk(0, -1, 3, 0, 0, 1, 0, 0, 3'b000, 0);
      vt[2].e[3] = mk(0, 1, -1, 0, 0, 0, 1, 0, 3'b000, 1);
      vt[3].din = 9'b011_101_101; vt[3].n = 3; vt[3].name = "sub R5,R5";
      vt[3].e[0] = ISS;
      vt[3].e[1] = mk(0, -1, 5, 0, 1, 0, 0, 0, 3'b000, 0);
      vt[3].e[2] = mk(0, -1, 5, 0, 0, 1, 0, 0, 3'b001, 0);
      vt[3].e[3] = mk(0, 5, -1, 0, 0, 0, 1, 0, 3'b000, 1);
      vt[4].din = 9'b100_000_111; vt[4].n = 3; vt[4].name = "nand R0,R7";
      vt[4].e[0] = ISS;
      vt[4].e[1] = mk(0, -1, 0, 0, 1, 0, 0, 0, 3'b000, 0);
      vt[4].e[2] = mk(0, -1, 7, 0, 0, 1, 0, 0, 3'b010, 0);
      vt[4].e[3] = mk(0, 0, -1, 0, 0, 0, 1, 0, 3'b000, 1);
      vt[5].din = 9'b101_111_000; vt[5].n = 3; vt[5].name = "out R7";
      vt[5].e[0] = ISS;
      vt[5].e[1] = mk(0, -1, 7, 0, 1, 0, 0, 0, 3'b000, 0);
      vt[5].e[2] = mk(0, -1, -1, 0, 0, 1, 0, 0, 3'b100, 0);
      vt[5].e[3] = mk(0, -1, -1, 0, 0, 0, 1, 1, 3'b000, 1);
`ifndef CU_ILLEGAL_TRAP_EN
      vt[6].din = 9'b110_000_000; vt[6].n = 1; vt[6].name = "nop 110";
      vt[6].e[0] = ISS; vt[6].e[1] = mk(0, -1, -1, 0, 0, 0, 0, 0, 3'b000, 1); vt[6].e[2] = Z; vt[6].e[3] = Z;
      vt[7].din = 9'b111_011_101; vt[7].n = 1; vt[7].name = "nop 111";
      vt[7].e[0] = ISS; vt[7].e[1] = mk(0, -1, -1, 0, 0, 0, 0, 0, 3'b000, 1); vt[7].e[2] = Z; vt[7].e[3] = Z;
`endif

      // Reset state, with Run asserted to show IRin is held off too
      bus.Run = 1'b1;
      bus.DIN = 9'b001_010_000;
      #2;
      check("reset outputs", sample(), Z);
      bus.Run = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         for (int k = 0; k <= vt[i].n; k++) sb.push_back(vt[i].e[k]);
         sb.push_back(Z);
         cycle(1'b1, vt[i].din, $sformatf("%s issue", vt[i].name));
         for (int k = 1; k <= vt[i].n; k++) cycle(1'b0, vt[i].din, $sformatf("%s T%0d", vt[i].name, k));
         cycle(1'b0, 9'b0, $sformatf("%s idle", vt[i].name));
      end

      // Run held high through an add: no IRin until the IDLE cycle after Done
      sb.push_back(ISS);
      sb.push_back(vt[2].e[1]);
      sb.push_back(vt[2].e[2]);
      sb.push_back(vt[2].e[3]);
      sb.push_back(ISS);
      sb.push_back(vt[0].e[1]);
      sb.push_back(Z);
      cycle(1'b1, 9'b010_001_011, "runhold issue");
      cycle(1'b1, 9'b001_010_000, "runhold T1");
      cycle(1'b1, 9'b001_010_000, "runhold T2");
      cycle(1'b1, 9'b001_010_000, "runhold T3");
      cycle(1'b1, 9'b001_010_000, "runhold next issue");
      cycle(1'b0, 9'b0, "runhold next T1");
      cycle(1'b0, 9'b0, "runhold idle");

      // Reset asserted during T2 abandons the add
      sb.push_back(ISS);
      sb.push_back(vt[2].e[1]);
      cycle(1'b1, 9'b010_001_011, "abort issue");
      cycle(1'b0, 9'b0, "abort T1");
      reset_pulse("abort in T2");
      for (int k = 0; k < 3; k++) begin
         sb.push_back(Z);
         cycle(1'b0, 9'b0, $sformatf("abort after %0d", k));
      end

`ifdef CU_ILLEGAL_TRAP_EN
      sb.push_back(ISS);
      sb.push_back(Z);
      cycle(1'b1, 9'b110_000_000, "trap issue");
      cycle(1'b0, 9'b0, "trap T1");
      for (int k = 0; k < 10; k++) begin
         sb.push_back(mk(0, -1, -1, 0, 0, 0, 0, 0, 3'b000, 0, 1'b1));
         cycle(1'b1, 9'b001_010_000, $sformatf("trap hold %0d", k));
      end
      reset_pulse("trap reset");
      for (int k = 0; k <= vt[0].n; k++) sb.push_back(vt[0].e[k]);
      cycle(1'b1, vt[0].din, "post-trap issue");
      cycle(1'b0, 9'b0, "post-trap T1");
`endif

      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
